// File: rtl/guitar_pkg.sv
// Shared lane enumeration, screen/width constants and the note slot record
// used by the note lane engine and its per-lane slot arrays.
package guitar_pkg;

    localparam int NUM_LANES = 5;
    localparam int SCREEN_H  = 480;
    localparam int Y_W       = 10;
    localparam int Y_EXT_W   = 11;

    typedef enum logic [2:0] {
        LANE_RED,
        LANE_BLUE,
        LANE_GREEN,
        LANE_YELLOW,
        LANE_ORANGE
    } lane_e;

    typedef struct packed {
        logic           valid;
        logic [Y_W-1:0] y;
    } note_slot_t;

endpackage

// File: rtl/note_lane_engine_if.sv
// Chart-sequencer / strum handshake bundle of the note lane engine.
interface note_lane_engine_if;
    import guitar_pkg::*;

    logic                 spawn_valid;
    logic [2:0]           spawn_lane;
    logic                 spawn_ready;
    logic                 strum_valid;
    logic [NUM_LANES-1:0] strum_mask;
    logic [NUM_LANES-1:0] hit_pulse;
    logic [NUM_LANES-1:0] miss_pulse;

    modport master (
        output spawn_valid, spawn_lane, strum_valid, strum_mask,
        input  spawn_ready, hit_pulse, miss_pulse
    );

    modport slave (
        input  spawn_valid, spawn_lane, strum_valid, strum_mask,
        output spawn_ready, hit_pulse, miss_pulse
    );
endinterface

// File: rtl/note_lane.sv
// One lane's note slots: free-slot finder, scroll/expire, hit search and
// unregistered pixel compare. All outputs are combinational from state.
module note_lane
    import guitar_pkg::*;
#(
    parameter int LANE_X  = 160,
    parameter int DEPTH   = 8,
    parameter int SPEED   = 4,
    parameter int NOTE_W  = 64,
    parameter int NOTE_H  = 16,
    parameter int HIT_Y   = 440,
    parameter int HIT_WIN = 12,
    parameter int SCR_H   = SCREEN_H
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           frame_tick_i,
    input  logic           spawn_i,
    input  logic           strum_i,
    input  logic [Y_W-1:0] draw_x_i,
    input  logic [Y_W-1:0] draw_y_i,
    output logic           free_o,
    output logic           hit_o,
    output logic           miss_o,
    output logic           pix_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [Y_EXT_W-1:0] X_LO   = Y_EXT_W'(LANE_X);
    localparam logic [Y_EXT_W-1:0] X_HI   = Y_EXT_W'(LANE_X + NOTE_W);
    localparam logic [Y_EXT_W-1:0] WIN_LO = Y_EXT_W'(HIT_Y - HIT_WIN);
    localparam logic [Y_EXT_W-1:0] WIN_HI = Y_EXT_W'(HIT_Y + HIT_WIN);
    localparam logic [Y_EXT_W-1:0] SPD    = Y_EXT_W'(SPEED);
    localparam logic [Y_EXT_W-1:0] SCR    = Y_EXT_W'(SCR_H);
    localparam logic [Y_EXT_W-1:0] NH     = Y_EXT_W'(NOTE_H);

    note_slot_t         slot_q [DEPTH];
    note_slot_t         slot_d [DEPTH];
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   hit_idx;
    logic [Y_EXT_W-1:0] y_ext;
    logic [Y_EXT_W-1:0] y_sum;
    logic [Y_EXT_W-1:0] dx_ext;
    logic [Y_EXT_W-1:0] dy_ext;

    always_comb begin
        slot_d   = slot_q;
        free_o   = 1'b0;
        hit_o    = 1'b0;
        miss_o   = 1'b0;
        pix_o    = 1'b0;
        free_idx = '0;
        hit_idx  = '0;
        y_ext    = '0;
        y_sum    = '0;
        dx_ext   = {1'b0, draw_x_i};
        dy_ext   = {1'b0, draw_y_i};

        for (int k = 0; k < DEPTH; k++) begin
            if (!slot_q[k].valid && !free_o) begin
                free_o   = 1'b1;
                free_idx = IDX_W'(k);
            end
        end

        // Window compared signed so a narrowed window below zero cannot wrap.
        for (int k = 0; k < DEPTH; k++) begin
            y_ext = {1'b0, slot_q[k].y};
            if (strum_i && slot_q[k].valid && !hit_o &&
                $signed(y_ext) >= $signed(WIN_LO) && $signed(y_ext) <= $signed(WIN_HI)) begin
                hit_o   = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end

        for (int k = 0; k < DEPTH; k++) begin
            y_ext = {1'b0, slot_q[k].y};
            y_sum = y_ext + SPD;
            if (slot_q[k].valid) begin
                if (hit_o && hit_idx == IDX_W'(k)) begin
                    slot_d[k] = '0;
                end else if (frame_tick_i) begin
                    if (y_sum >= SCR) begin
                        slot_d[k] = '0;
                        miss_o    = 1'b1;
                    end else begin
                        slot_d[k].y = y_sum[Y_W-1:0];
                    end
                end
                if (dx_ext >= X_LO && dx_ext < X_HI && dy_ext >= y_ext && dy_ext < y_ext + NH)
                    pix_o = 1'b1;
            end
        end

        // The spawn target was free before this cycle, so hit/scroll never touch it.
        if (spawn_i && free_o) begin
            slot_d[free_idx].valid = 1'b1;
            slot_d[free_idx].y     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) slot_q[k] <= slot_d[k];
        end
    end
endmodule

// File: rtl/note_lane_engine.sv
// Five-lane note sprite engine: spawn decode, registered sprite/hit/miss outputs.
// Optional score/streak counters are built when NOTE_SCORE_EN is defined.
module note_lane_engine
    import guitar_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int SPEED      = 4,
    parameter int NOTE_W     = 64,
    parameter int NOTE_H     = 16,
    parameter int LANE_X0    = 160,
    parameter int LANE_PITCH = 64,
    parameter int HIT_Y      = 440,
    parameter int HIT_WIN    = 12,
    parameter int SCR_H      = SCREEN_H
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           frame_tick,
    note_lane_engine_if.slave bus,
    input  logic [Y_W-1:0] DrawX,
    input  logic [Y_W-1:0] DrawY,
`ifdef NOTE_SCORE_EN
    output logic [15:0]    score,
    output logic [7:0]     streak,
`endif
    output logic           is_sprite_red,
    output logic           is_sprite_blue,
    output logic           is_sprite_green,
    output logic           is_sprite_yellow,
    output logic           is_sprite_orange
);
    logic [NUM_LANES-1:0] lane_free;
    logic [NUM_LANES-1:0] spawn_sel;
    logic [NUM_LANES-1:0] sprite_d, sprite_q;
    logic [NUM_LANES-1:0] hit_d, hit_q;
    logic [NUM_LANES-1:0] miss_d, miss_q;
    logic                 free_sel;
    logic                 ready;

    // Lanes 5-7 match no index, so illegal lanes are never ready.
    always_comb begin
        free_sel  = 1'b0;
        spawn_sel = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (bus.spawn_lane == 3'(i)) free_sel = lane_free[i];
        ready = Reset_n && !frame_tick && free_sel;
        for (int i = 0; i < NUM_LANES; i++)
            spawn_sel[i] = bus.spawn_valid && ready && (bus.spawn_lane == 3'(i));
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        note_lane #(
            .LANE_X (LANE_X0 + i * LANE_PITCH),
            .DEPTH  (DEPTH),
            .SPEED  (SPEED),
            .NOTE_W (NOTE_W),
            .NOTE_H (NOTE_H),
            .HIT_Y  (HIT_Y),
            .HIT_WIN(HIT_WIN),
            .SCR_H  (SCR_H)
        ) u_lane (
            .clk_i       (Clk),
            .rst_n_i     (Reset_n),
            .frame_tick_i(frame_tick),
            .spawn_i     (spawn_sel[i]),
            .strum_i     (bus.strum_valid && bus.strum_mask[i]),
            .draw_x_i    (DrawX),
            .draw_y_i    (DrawY),
            .free_o      (lane_free[i]),
            .hit_o       (hit_d[i]),
            .miss_o      (miss_d[i]),
            .pix_o       (sprite_d[i])
        );
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sprite_q <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            sprite_q <= sprite_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign bus.spawn_ready = ready;
    assign bus.hit_pulse   = hit_q;
    assign bus.miss_pulse  = miss_q;

    assign is_sprite_red    = sprite_q[LANE_RED];
    assign is_sprite_blue   = sprite_q[LANE_BLUE];
    assign is_sprite_green  = sprite_q[LANE_GREEN];
    assign is_sprite_yellow = sprite_q[LANE_YELLOW];
    assign is_sprite_orange = sprite_q[LANE_ORANGE];

`ifdef NOTE_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [7:0]  streak_q, streak_d;
    logic [2:0]  hit_cnt;
    logic [16:0] score_sum;
    logic [8:0]  streak_sum;

    // Counts follow the registered pulses, so they trail hit_pulse by a cycle.
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) hit_cnt = hit_cnt + {2'b00, hit_q[i]};
        score_sum  = {1'b0, score_q} + 17'(hit_cnt);
        streak_sum = {1'b0, streak_q} + 9'(hit_cnt);
        score_d    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (|miss_q)            streak_d = '0;
        else if (streak_sum[8]) streak_d = 8'hFF;
        else                    streak_d = streak_sum[7:0];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_q  <= '0;
            streak_q <= '0;
        end else begin
            score_q  <= score_d;
            streak_q <= streak_d;
        end
    end

    assign score  = score_q;
    assign streak = streak_q;
`endif
endmodule
